packet_replicator: RTL and testbench
====================================

# packet_replicator

Parametrised N-way packet replicator for the NetFPGA-10G AXI4-Stream datapath. It sits after output_port_lookup, in place of the fixed two-port duplicator. Each accepted packet is copied to any subset of NUM_OUTPUTS master ports, selected per packet by a mask. All selected copies drain concurrently through independent per-output FIFOs, and each copy has its tuser destination byte rewritten per output.

## Interface
Parameters:
- C_M_AXIS_DATA_WIDTH, 256, tdata width (both sides); tstrb width = width/8
- C_M_AXIS_TUSER_WIDTH, 128, tuser width (both sides); must be ≥ 32
- NUM_OUTPUTS, 4, number of master ports, 1..8
- FIFO_DEPTH_BITS, 4, per-output FIFO depth = 2**FIFO_DEPTH_BITS beats

Ports (clock and reset first; master buses flattened, output i at slice i):
- axi_aclk  in  1  clock; all logic on rising edge
- axi_aresetn  in  1  asynchronous, active-low reset
- s_axis_tdata / tstrb / tuser / tlast  in  W / W/8 / U / 1  upstream beat
- s_axis_tvalid  in  1  upstream valid
- s_axis_tready  out  1  upstream ready
- port_mask  in  NUM_OUTPUTS  output-select mask; sampled at start-of-packet only
- dst_ports  in  8*NUM_OUTPUTS  per-output value written into tuser[31:24]
- m_axis_tdata / tstrb / tuser / tlast  out  N*W / N*W/8 / N*U / N  per-output beat
- m_axis_tvalid  out  N  per-output valid
- m_axis_tready  in  N  per-output ready

## Operation
- State machine: SOP (awaiting first beat) and PKT (mid-packet). Reset state is SOP.
- Active mask: in SOP it is port_mask (combinational); in PKT it is the latched pkt_mask.
- Accept rule: s_axis_tready = 1 when no FIFO i with active_mask[i]=1 is full. A beat is accepted when s_axis_tvalid & s_axis_tready.
- On an accepted beat, the beat is written into every FIFO i with active_mask[i]=1, in the same cycle.
- SOP + accept: pkt_mask <= port_mask. If tlast=0, go to PKT; if tlast=1 (single-beat packet), stay in SOP.
- PKT + accept + tlast: go to SOP.
- The first beat of each copy has tuser[31:24] replaced by dst_ports[8i+7:8i]. All other beats and bits pass unchanged.
- Mask all-zero: tready=1 and all beats of the packet are consumed and discarded (drop). A zero mask is latched like any other.
- Output i: m_axis_tvalid[i] = !empty_i, with data taken from the FIFO head. Pop on tvalid & tready. Outputs are independent; a stalled output only blocks input once its FIFO fills.
- port_mask changes while in PKT have no effect on the current packet.
- Reset mid-packet: state goes to SOP, all FIFOs are emptied, pkt_mask=0, and partial packets are discarded.

## Timing
- Reset values: s_axis_tready=0 while axi_aresetn=0, then combinational (1 at the first cycle after deassert). m_axis_tvalid=0, m_axis_tlast=0, and FIFO counts=0.
- Latency: a beat accepted at edge k appears on m_axis_t*[i] with tvalid=1 after edge k (fallthrough); it can pop at edge k+1.
- Simultaneous push and pop on a full FIFO: the FIFO is treated as full for tready, so no push happens (no bypass). Simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- Throughput: 1 beat/cycle when all selected outputs hold tready=1.
- s_axis_tready is combinational from FIFO full flags, state and port_mask. It has no dependence on m_axis_tready in the same cycle.

## Configuration
- PACKET_REPLICATOR_STATS_EN defined: adds output port pkt_count (out, 32*NUM_OUTPUTS). Counter i increments on each popped beat with tlast=1 on output i, wraps at 2**32, and resets to 0. Also adds drop_count (out, 32), which increments on the tlast beat of each zero-mask packet.
- Not defined: these ports and counters do not exist, and behaviour is otherwise identical.

## Test plan
- NUM_OUTPUTS=4, port_mask=4'b1011, dst_ports={8'h80,8'h40,8'h20,8'h10}, 3-beat packet, all readies=1 -> outputs 0, 1 and 3 each emit 3 beats, starting the cycle after acceptance. The first-beat tuser[31:24] values are 0x10, 0x20 and 0x80 respectively. Output 2 emits none.
- Hold m_axis_tready[1]=0, mask=4'b0011, FIFO_DEPTH_BITS=4, 20-beat packet -> s_axis_tready drops after 16 beats while output 0 drains all 16. Releasing ready[1] completes both copies with identical data.
- port_mask toggled to 4'b0100 mid-packet -> the packet finishes on its original outputs, and the next packet goes only to output 2.
- port_mask=0, 5-beat packet -> tready=1 throughout, no m_axis_tvalid, drop_count=1 (STATS_EN).
- Back-to-back single-beat packets with alternating masks 4'b0001/4'b1000 -> 1 beat/cycle is accepted and each output receives every other packet.
- axi_aresetn asserted after beat 2 of a 4-beat packet -> all m_axis_tvalid=0 immediately. After release, the next packet arrives intact with no stale beats.

Source files
------------

// File: rtl/packet_replicator.sv
// packet_replicator: N-way AXI4-Stream packet replicator.
// Each accepted packet is written into the per-output FIFO of every output
// selected by port_mask (sampled at start of packet). The first beat of each
// copy has tuser[31:24] replaced by that output's dst_ports byte.
// Optional build macro: PACKET_REPLICATOR_STATS_EN adds pkt_count/drop_count.
module packet_replicator #(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int NUM_OUTPUTS          = 4,
   parameter int FIFO_DEPTH_BITS      = 4
) (
   input  logic                                              axi_aclk,
   input  logic                                              axi_aresetn,
   input  logic [C_M_AXIS_DATA_WIDTH-1:0]                    s_axis_tdata,
   input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]                  s_axis_tstrb,
   input  logic [C_M_AXIS_TUSER_WIDTH-1:0]                   s_axis_tuser,
   input  logic                                              s_axis_tlast,
   input  logic                                              s_axis_tvalid,
   output logic                                              s_axis_tready,
   input  logic [NUM_OUTPUTS-1:0]                            port_mask,
   input  logic [8*NUM_OUTPUTS-1:0]                          dst_ports,
   output logic [NUM_OUTPUTS*C_M_AXIS_DATA_WIDTH-1:0]        m_axis_tdata,
   output logic [NUM_OUTPUTS*C_M_AXIS_DATA_WIDTH/8-1:0]      m_axis_tstrb,
   output logic [NUM_OUTPUTS*C_M_AXIS_TUSER_WIDTH-1:0]       m_axis_tuser,
   output logic [NUM_OUTPUTS-1:0]                            m_axis_tlast,
   output logic [NUM_OUTPUTS-1:0]                            m_axis_tvalid,
   input  logic [NUM_OUTPUTS-1:0]                            m_axis_tready
`ifdef PACKET_REPLICATOR_STATS_EN
   ,
   output logic [32*NUM_OUTPUTS-1:0]                         pkt_count,
   output logic [31:0]                                       drop_count
`endif
);

   localparam int W      = C_M_AXIS_DATA_WIDTH;
   localparam int SW     = C_M_AXIS_DATA_WIDTH/8;
   localparam int U      = C_M_AXIS_TUSER_WIDTH;
   localparam int DEPTH  = 2**FIFO_DEPTH_BITS;
   localparam int PTR_W  = FIFO_DEPTH_BITS;
   localparam int CNT_W  = FIFO_DEPTH_BITS + 1;

   localparam logic ST_SOP = 1'b0;
   localparam logic ST_PKT = 1'b1;

   logic                   state_q, state_d;
   logic [NUM_OUTPUTS-1:0] pkt_mask_q, pkt_mask_d;
   logic [NUM_OUTPUTS-1:0] active_mask;
   logic [NUM_OUTPUTS-1:0] fifo_full;
   logic                   accept;
   logic                   first_beat;

   // Output selection and upstream flow control
   always_comb begin
      active_mask   = (state_q == ST_SOP) ? port_mask : pkt_mask_q;
      first_beat    = (state_q == ST_SOP);
      s_axis_tready = axi_aresetn & ~(|(active_mask & fifo_full));
      accept        = s_axis_tvalid & s_axis_tready;
   end

   // Packet-framing next-state logic
   always_comb begin
      state_d    = state_q;
      pkt_mask_d = pkt_mask_q;
      if (accept) begin
         if (state_q == ST_SOP) begin
            pkt_mask_d = port_mask;
            state_d    = s_axis_tlast ? ST_SOP : ST_PKT;
         end else if (s_axis_tlast) begin
            state_d = ST_SOP;
         end
      end
   end

   // Framing state registers
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state_q    <= ST_SOP;
         pkt_mask_q <= '0;
      end else begin
         state_q    <= state_d;
         pkt_mask_q <= pkt_mask_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_out
         logic [W-1:0]     data_mem [DEPTH];
         logic [SW-1:0]    strb_mem [DEPTH];
         logic [U-1:0]     user_mem [DEPTH];
         logic             last_mem [DEPTH];
         logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
         logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
         logic [CNT_W-1:0] count_q, count_d;
         logic [U-1:0]     wr_user;
         logic             push, pop, empty;

         // Per-copy tuser rewrite on the first beat
         always_comb begin
            wr_user = s_axis_tuser;
            if (first_beat) wr_user[31:24] = dst_ports[8*gi +: 8];
         end

         // FIFO pointer and occupancy next-state
         always_comb begin
            empty    = (count_q == '0);
            push     = accept & active_mask[gi];
            pop      = ~empty & m_axis_tready[gi];
            wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
            rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
            count_d  = count_q;
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
         end

         // Count only reaches DEPTH when full, so its MSB is the full flag
         assign fifo_full[gi] = count_q[CNT_W-1];

         // FIFO control registers
         always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
            if (!axi_aresetn) begin
               wr_ptr_q <= '0;
               rd_ptr_q <= '0;
               count_q  <= '0;
            end else begin
               wr_ptr_q <= wr_ptr_d;
               rd_ptr_q <= rd_ptr_d;
               count_q  <= count_d;
            end
         end

         // FIFO storage write
         always_ff @(posedge axi_aclk) begin
            if (push) begin
               data_mem[wr_ptr_q] <= s_axis_tdata;
               strb_mem[wr_ptr_q] <= s_axis_tstrb;
               user_mem[wr_ptr_q] <= wr_user;
               last_mem[wr_ptr_q] <= s_axis_tlast;
            end
         end

         // Fallthrough head of FIFO drives the master port
         always_comb begin
            m_axis_tvalid[gi]            = ~empty;
            m_axis_tlast[gi]             = ~empty & last_mem[rd_ptr_q];
            m_axis_tdata[gi*W +: W]      = data_mem[rd_ptr_q];
            m_axis_tstrb[gi*SW +: SW]    = strb_mem[rd_ptr_q];
            m_axis_tuser[gi*U +: U]      = user_mem[rd_ptr_q];
         end

`ifdef PACKET_REPLICATOR_STATS_EN
         logic [31:0] pkt_cnt_q;
         // Packets delivered on this output
         always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
            if (!axi_aresetn)                pkt_cnt_q <= '0;
            else if (pop && m_axis_tlast[gi]) pkt_cnt_q <= pkt_cnt_q + 32'd1;
         end
         assign pkt_count[32*gi +: 32] = pkt_cnt_q;
`endif
      end
   endgenerate

`ifdef PACKET_REPLICATOR_STATS_EN
   logic [31:0] drop_cnt_q;
   // Zero-mask packets, counted on their last beat
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn)
         drop_cnt_q <= '0;
      else if (accept && s_axis_tlast && (active_mask == '0))
         drop_cnt_q <= drop_cnt_q + 32'd1;
   end
   assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_packet_replicator.sv
// Scoreboard testbench for packet_replicator (NUM_OUTPUTS=4, depth 16).
module tb_packet_replicator;

   localparam int N  = 4;
   localparam int W  = 256;
   localparam int SW = 32;
   localparam int U  = 128;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [W-1:0]    s_tdata;
   logic [SW-1:0]   s_tstrb;
   logic [U-1:0]    s_tuser;
   logic            s_tlast;
   logic            s_tvalid;
   logic            s_tready;
   logic [N-1:0]    port_mask;
   logic [8*N-1:0]  dst_ports;
   logic [N*W-1:0]  m_tdata;
   logic [N*SW-1:0] m_tstrb;
   logic [N*U-1:0]  m_tuser;
   logic [N-1:0]    m_tlast;
   logic [N-1:0]    m_tvalid;
   logic [N-1:0]    m_tready;
`ifdef PACKET_REPLICATOR_STATS_EN
   logic [32*N-1:0] pkt_count;
   logic [31:0]     drop_count;
`endif

   packet_replicator #(
      .C_M_AXIS_DATA_WIDTH (W),
      .C_M_AXIS_TUSER_WIDTH(U),
      .NUM_OUTPUTS         (N),
      .FIFO_DEPTH_BITS     (4)
   ) dut (
      .axi_aclk     (clk),
      .axi_aresetn  (rst_n),
      .s_axis_tdata (s_tdata),
      .s_axis_tstrb (s_tstrb),
      .s_axis_tuser (s_tuser),
      .s_axis_tlast (s_tlast),
      .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready),
      .port_mask    (port_mask),
      .dst_ports    (dst_ports),
      .m_axis_tdata (m_tdata),
      .m_axis_tstrb (m_tstrb),
      .m_axis_tuser (m_tuser),
      .m_axis_tlast (m_tlast),
      .m_axis_tvalid(m_tvalid),
      .m_axis_tready(m_tready)
`ifdef PACKET_REPLICATOR_STATS_EN
      ,
      .pkt_count    (pkt_count),
      .drop_count   (drop_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]  d;
      logic [SW-1:0] s;
      logic [U-1:0]  u;
      logic          l;
   } beat_t;

   beat_t expq [N][$];

   int checks = 0;
   int errors = 0;
   int beats_acc = 0;
   int stall_cnt = 0;

   function automatic logic [W-1:0] mk_data(input logic [31:0] s);
      return {4{s, ~s}};
   endfunction

   function automatic logic [U-1:0] mk_user(input logic [31:0] s);
      return {4{s ^ 32'hC3C3_3C3C}};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Scoreboard monitor: compare every beat an output presents and hands off
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (m_tvalid[i]) begin
            if (expq[i].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat out%0d: tvalid=1 with no expected beat", i);
            end else if (m_tready[i]) begin
               beat_t e;
               e = expq[i].pop_front();
               checks++;
               if (m_tdata[i*W +: W] !== e.d || m_tstrb[i*SW +: SW] !== e.s ||
                   m_tuser[i*U +: U] !== e.u || m_tlast[i] !== e.l) begin
                  errors++;
                  $display("FAIL beat out%0d: got user=%0h last=%0b data[31:0]=%0h, expected user=%0h last=%0b data[31:0]=%0h",
                           i, m_tuser[i*U +: U], m_tlast[i], m_tdata[i*W +: 32], e.u, e.l, e.d[31:0]);
               end
            end
         end
      end
   end

   // Present one beat and wait (bounded) for it to be accepted; called at posedge+1
   task automatic send_beat(input logic [31:0] seed, input logic last, input logic [N-1:0] pm,
                            input logic [N-1:0] emask, input logic first);
      int waited;
      s_tdata   = mk_data(seed);
      s_tstrb   = seed;
      s_tuser   = mk_user(seed);
      s_tlast   = last;
      s_tvalid  = 1'b1;
      port_mask = pm;
      waited    = 0;
      @(negedge clk);
      while (!s_tready && waited < 200) begin
         waited++;
         @(negedge clk);
      end
      stall_cnt += waited;
      if (!s_tready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: tready=0 after %0d cycles, expected 1", waited);
         return;
      end
      for (int i = 0; i < N; i++) begin
         if (emask[i]) begin
            beat_t e;
            e.d = mk_data(seed);
            e.s = seed;
            e.u = mk_user(seed);
            if (first) e.u[31:24] = dst_ports[i*8 +: 8];
            e.l = last;
            expq[i].push_back(e);
         end
      end
      @(posedge clk);
      #1;
      beats_acc++;
   endtask

   task automatic idle();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic send_pkt(input int n, input logic [N-1:0] mask, input logic [N-1:0] alt,
                           input logic [31:0] base);
      for (int j = 0; j < n; j++)
         send_beat(base + 32'(j), j == n-1, (j == 0) ? mask : alt, mask, j == 0);
      idle();
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((expq[0].size() + expq[1].size() + expq[2].size() + expq[3].size()) != 0 && t < 500) begin
         @(posedge clk);
         t++;
      end
      #1;
      check("drain_complete", 128'(expq[0].size() + expq[1].size() + expq[2].size() + expq[3].size()), 128'd0);
   endtask

   initial begin
      int base_beats, base_stall;
      rst_n     = 1'b0;
      s_tdata   = '0;
      s_tstrb   = '0;
      s_tuser   = '0;
      s_tlast   = 1'b0;
      s_tvalid  = 1'b0;
      port_mask = '0;
      dst_ports = {8'h80, 8'h40, 8'h20, 8'h10};
      m_tready  = '1;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_tready", 128'(s_tready), 128'd0);
      check("reset_tvalid", 128'(m_tvalid), 128'd0);
      check("reset_tlast",  128'(m_tlast),  128'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("tready_after_reset", 128'(s_tready), 128'd1);
      @(posedge clk);
      #1;

      // 3-beat packet to outputs 0,1,3 with per-output tuser byte
      send_beat(32'h100, 1'b0, 4'b1011, 4'b1011, 1'b1);
      idle();
      @(negedge clk);
      check("latency_tvalid", 128'(m_tvalid), 128'(4'b1011));
      check("dst_byte_out0", 128'(m_tuser[0*U+24 +: 8]), 128'h10);
      check("dst_byte_out1", 128'(m_tuser[1*U+24 +: 8]), 128'h20);
      check("dst_byte_out3", 128'(m_tuser[3*U+24 +: 8]), 128'h80);
      @(posedge clk);
      #1;
      send_beat(32'h101, 1'b0, 4'b0000, 4'b1011, 1'b0);
      send_beat(32'h102, 1'b1, 4'b0000, 4'b1011, 1'b0);
      idle();
      drain();

      // Backpressure: output 1 stalled, 20-beat packet to outputs 0,1
      m_tready   = 4'b1101;
      base_beats = beats_acc;
      fork
         send_pkt(20, 4'b0011, 4'b0011, 32'h200);
         begin
            repeat (40) @(negedge clk);
            check("bp_beats_accepted", 128'(beats_acc - base_beats), 128'd16);
            check("bp_tready_low", 128'(s_tready), 128'd0);
            check("bp_out0_drained", 128'(expq[0].size()), 128'd0);
            check("bp_out1_holding", 128'(expq[1].size()), 128'd16);
            @(posedge clk);
            #1 m_tready = '1;
         end
      join
      drain();

      // port_mask change mid-packet affects only the next packet
      send_pkt(3, 4'b0011, 4'b0100, 32'h300);
      send_pkt(2, 4'b0100, 4'b0100, 32'h310);
      drain();

      // Zero mask: packet is dropped without backpressure
      base_stall = stall_cnt;
      send_pkt(5, 4'b0000, 4'b0000, 32'h400);
      repeat (3) @(negedge clk);
      check("drop_no_stall", 128'(stall_cnt - base_stall), 128'd0);
      check("drop_no_tvalid", 128'(m_tvalid), 128'd0);
`ifdef PACKET_REPLICATOR_STATS_EN
      check("drop_count", 128'(drop_count), 128'd1);
`endif
      @(posedge clk);
      #1;

      // Back-to-back single-beat packets, alternating masks
      base_stall = stall_cnt;
      for (int p = 0; p < 6; p++)
         send_beat(32'h500 + 32'(p), 1'b1, (p % 2 == 0) ? 4'b0001 : 4'b1000,
                   (p % 2 == 0) ? 4'b0001 : 4'b1000, 1'b1);
      idle();
      check("b2b_no_stall", 128'(stall_cnt - base_stall), 128'd0);
      drain();

      // Reset in the middle of a 4-beat packet
      m_tready = '0;
      send_beat(32'h600, 1'b0, 4'b1111, 4'b1111, 1'b1);
      send_beat(32'h601, 1'b0, 4'b0000, 4'b1111, 1'b0);
      idle();
      rst_n = 1'b0;
      #1;
      check("midreset_tvalid", 128'(m_tvalid), 128'd0);
      check("midreset_tready", 128'(s_tready), 128'd0);
      for (int i = 0; i < N; i++) expq[i].delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      m_tready = '1;
      @(negedge clk);
      check("postreset_tready", 128'(s_tready), 128'd1);
      check("postreset_tvalid", 128'(m_tvalid), 128'd0);
      @(posedge clk);
      #1;
      send_pkt(4, 4'b1111, 4'b1111, 32'h700);
      drain();
      repeat (3) @(negedge clk);
      check("final_no_tvalid", 128'(m_tvalid), 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
